// File: rtl/oup_ulpi_cmd_arbiter.sv
// Round-robin arbiter for ULPI register-write, register-read and transmit commands.
// It issues one command at a time to the sync-mode state machine, with abort retry and a response timeout.
module oup_ulpi_cmd_arbiter #(
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_i,

    input  logic       wr_req_i,
    input  logic [5:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_done_o,
    output logic       wr_err_o,

    input  logic       rd_req_i,
    input  logic [5:0] rd_addr_i,
    output logic       rd_done_o,
    output logic       rd_err_o,
    output logic [7:0] rd_data_o,

    input  logic       tx_req_i,
    input  logic [3:0] tx_pid_i,
    output logic       tx_done_o,
    output logic       tx_err_o,

    output logic [7:0] instruction_o,
    output logic       exec_o,
    input  logic       exec_done_i,
    input  logic       exec_aborted_i,
    output logic [7:0] phyreg_o,
    output logic [7:0] phyreg_addr_o,
    input  logic [7:0] phyreg_i,

    output logic       busy_o
);

    localparam logic [1:0] G_WR = 2'd0;
    localparam logic [1:0] G_RD = 2'd1;
    localparam logic [1:0] G_TX = 2'd2;

    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BACKOFF,
        S_COMPLETE
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_gnt;
    logic [2:0] r_retry;
    logic [9:0] r_cnt;
    logic [7:0] r_instr;
    logic [7:0] r_phyreg;
    logic [7:0] r_phyaddr;
    logic [7:0] r_rd_data;
    logic       r_exec;
    logic [2:0] r_done;
    logic [2:0] r_err;

    logic       w_any;
    logic [1:0] w_pick;
    logic [7:0] w_instr;
    logic [7:0] w_phyreg;
    logic [7:0] w_phyaddr;
    logic [2:0] w_gnt_oh;

    // Winner is the first active requester after the last-granted one, in wr -> rd -> tx order.
    always_comb begin
        w_any  = wr_req_i | rd_req_i | tx_req_i;
        w_pick = G_WR;
        case (r_last)
            G_WR: begin
                if (rd_req_i)      w_pick = G_RD;
                else if (tx_req_i) w_pick = G_TX;
                else               w_pick = G_WR;
            end
            G_RD: begin
                if (tx_req_i)      w_pick = G_TX;
                else if (wr_req_i) w_pick = G_WR;
                else               w_pick = G_RD;
            end
            default: begin
                if (wr_req_i)      w_pick = G_WR;
                else if (rd_req_i) w_pick = G_RD;
                else               w_pick = G_TX;
            end
        endcase
    end

    always_comb begin
        w_instr   = 8'h00;
        w_phyreg  = 8'h00;
        w_phyaddr = 8'h00;
        case (w_pick)
            G_WR: begin
                w_instr   = {2'b10, wr_addr_i};
                w_phyreg  = wr_data_i;
                w_phyaddr = {2'b00, wr_addr_i};
            end
            G_RD: begin
                w_instr   = {2'b11, rd_addr_i};
                w_phyaddr = {2'b00, rd_addr_i};
            end
            default: begin
                w_instr   = {4'h4, tx_pid_i};
            end
        endcase
    end

    assign w_gnt_oh = 3'b001 << r_gnt;

    always_ff @(posedge ulpi_clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_last    <= G_TX;
            r_gnt     <= G_WR;
            r_retry   <= 3'd0;
            r_cnt     <= 10'd0;
            r_instr   <= 8'h00;
            r_phyreg  <= 8'h00;
            r_phyaddr <= 8'h00;
            r_rd_data <= 8'h00;
            r_exec    <= 1'b0;
            r_done    <= 3'b000;
            r_err     <= 3'b000;
        end else begin
            r_exec <= 1'b0;
            r_done <= 3'b000;
            r_err  <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_pick;
                        r_instr   <= w_instr;
                        r_phyreg  <= w_phyreg;
                        r_phyaddr <= w_phyaddr;
                        r_exec    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 10'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // exec_done_i wins over a simultaneous abort.
                    if (exec_done_i) begin
                        r_done  <= w_gnt_oh;
                        if (r_gnt == G_RD) r_rd_data <= phyreg_i;
                        r_state <= S_COMPLETE;
                    end else if (exec_aborted_i) begin
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 3'd1;
                            r_state <= S_BACKOFF;
                        end else begin
                            r_err   <= w_gnt_oh;
                            r_state <= S_COMPLETE;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_err   <= w_gnt_oh;
                        r_state <= S_COMPLETE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_BACKOFF: begin
                    r_exec  <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_COMPLETE: begin
                    r_last  <= r_gnt;
                    r_retry <= 3'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instruction_o = r_instr;
    assign phyreg_o      = r_phyreg;
    assign phyreg_addr_o = r_phyaddr;
    assign rd_data_o     = r_rd_data;
    assign exec_o        = r_exec;
    assign busy_o        = (r_state != S_IDLE);

    assign wr_done_o = r_done[0];
    assign rd_done_o = r_done[1];
    assign tx_done_o = r_done[2];
    assign wr_err_o  = r_err[0];
    assign rd_err_o  = r_err[1];
    assign tx_err_o  = r_err[2];

endmodule

// File: doc/oup_ulpi_cmd_arbiter.md
OUP_ULPI_CMD_ARBITER -- requirements
Module: oup_ulpi_cmd_arbiter

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, the number of re-issues allowed after exec_aborted_i (0-7).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, the maximum number of cycles WAIT may last before an error is declared (max 1023).
REQ-003 SHALL use a single clock and a synchronous, active-high reset: ulpi_clk_i  in  1  sole clock; rst_i  in  1  synchronous active-high reset.
REQ-004 SHALL have ports wr_req_i  in  1, wr_addr_i  in  6, wr_data_i  in  8: the PHY register-write requester.
REQ-005 SHALL have ports wr_done_o  out  1, wr_err_o  out  1: register-write completion pulses.
REQ-006 SHALL have ports rd_req_i  in  1, rd_addr_i  in  6: the PHY register-read requester.
REQ-007 SHALL have ports rd_done_o  out  1, rd_err_o  out  1, rd_data_o  out  8: register-read completion pulses and read data.
REQ-008 SHALL have ports tx_req_i  in  1, tx_pid_i  in  4, tx_done_o  out  1, tx_err_o  out  1: the USB transmit requester.
REQ-009 SHALL have ports instruction_o  out  8, exec_o  out  1, exec_done_i  in  1, exec_aborted_i  in  1: the link to the ULPI sync-mode state machine.
REQ-010 SHALL have ports phyreg_o  out  8, phyreg_addr_o  out  8, phyreg_i  in  8: register data and address to and from the ULPI sync-mode state machine.
REQ-011 SHALL have port busy_o  out  1, high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, BACKOFF, COMPLETE.
REQ-013 SHALL, in IDLE with any request high, latch the grant, the opcode and the operands at the clock edge, then enter ISSUE.
REQ-014 SHALL arbitrate round-robin in the order wr -> rd -> tx: the first requester after the last-granted one wins; after reset the pointer favours wr.
REQ-015 SHALL encode instruction_o as wr = 8'h80|addr, rd = 8'hC0|addr, tx = 8'h40|{4'h0,pid}; phyreg_addr_o = {2'b00,addr}; phyreg_o = wr_data for wr, else 8'h00.
REQ-016 SHALL hold instruction_o, phyreg_o and phyreg_addr_o stable from ISSUE until return to IDLE.
REQ-017 SHALL pulse exec_o high for exactly one cycle in ISSUE, then enter WAIT with the timeout counter cleared.
REQ-018 SHALL, in WAIT on exec_done_i, enter COMPLETE; for a rd grant, rd_data_o SHALL capture phyreg_i in the same cycle.
REQ-019 SHALL, in WAIT on exec_aborted_i: if the retry count < MAX_RETRY, increment it and go to BACKOFF; otherwise go to COMPLETE flagged as an error.
REQ-020 SHALL make BACKOFF last exactly 1 cycle and then return to ISSUE, re-issuing the identical instruction.
REQ-021 SHALL, when the WAIT counter reaches TIMEOUT_CYCLES with neither input seen, go to COMPLETE flagged as an error, without retry.
REQ-022 SHALL give exec_done_i priority if it and exec_aborted_i are high in the same cycle; SHALL ignore both inputs outside WAIT.
REQ-023 SHALL, in COMPLETE, pulse exactly one of the granted requester's done_o/err_o for 1 cycle, advance the round-robin pointer, clear the retry count, and return to IDLE.
REQ-024 SHALL make the minimum request-to-done latency 4 cycles: req sampled in cycle N, exec_o in N+1, exec_done_i in N+2, done_o in N+3.
REQ-025 SHALL re-sample requests only in IDLE; deasserting a request after grant SHALL NOT cancel the operation, and its pulse still occurs.
REQ-026 SHALL hold rd_data_o until the next successful read; rd_err_o SHALL leave rd_data_o unchanged.

Reset
REQ-027 SHALL, with rst_i high at an edge, force IDLE, retry count 0, timeout counter 0 and pointer to wr.
REQ-028 SHALL reset all outputs to 0: instruction_o, phyreg_o, phyreg_addr_o and rd_data_o to 8'h00; exec_o, busy_o and all done/err pulses to 0.
REQ-029 SHALL, on reset asserted mid-operation (any non-IDLE state), abandon the operation with no done/err pulse.

Verification
REQ-030 SHALL pass this test: wr_req, addr 6'h0A, data 8'h55, exec_done_i 1 cycle after exec_o -> instruction_o 8'h8A, phyreg_o 8'h55, phyreg_addr_o 8'h0A, single exec_o pulse, wr_done_o 2 cycles after exec_o.
REQ-031 SHALL pass this test: rd_req, addr 6'h01, phyreg_i 8'h24 with exec_done_i -> instruction_o 8'hC1, rd_done_o pulse, rd_data_o 8'h24 held.
REQ-032 SHALL pass this test: wr, rd and tx requests all held high continuously -> grants in order wr, rd, tx, wr; each done once per grant.
REQ-033 SHALL pass this test: tx pid 4'h3, exec_aborted_i on every attempt -> instruction_o 8'h43, exactly 4 exec_o pulses, each separated by 1 BACKOFF cycle, then tx_err_o.
REQ-034 SHALL pass this test: TIMEOUT_CYCLES=8, no response -> err_o pulse after 8 WAIT cycles, 1 exec_o only; simultaneous exec_done_i and exec_aborted_i -> done_o.
REQ-035 SHALL pass this test: rst_i asserted during WAIT -> next cycle busy_o 0 and all outputs 0, no done/err pulse.
